// File: rtl/repeater_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : repeater_fifo_rd_arbiter
// Brief   : Round-robin arbiter and burst sequencer for the repeater FIFO read port.
// Revision: 1.0
// ============================================================================
module repeater_fifo_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 10,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*LEN_W-1:0] req_len_i,
  output logic [N_REQ-1:0]       gnt_o,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_o,
  input  logic [DAT_W-1:0]       fifo_rd_dat_i,
  input  logic                   fifo_rd_dat_valid_i,
  output logic [DAT_W-1:0]       dat_o,
  output logic [N_REQ-1:0]       dat_valid_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       err_o
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = LEN_W + 1;
  localparam int ECNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [PTR_W-1:0]  ptr_q,        ptr_d;
  logic [LEN_W-1:0]  len_q,        len_d;
  logic [CNT_W-1:0]  issued_q,     issued_d;
  logic [CNT_W-1:0]  rcvd_q,       rcvd_d;
  logic [ECNT_W-1:0] ecnt_q,       ecnt_d;
  logic              err_pend_q,   err_pend_d;
  logic [N_REQ-1:0]  gnt_q,        gnt_d;
  logic [DAT_W-1:0]  dat_q,        dat_d;
  logic [N_REQ-1:0]  dat_valid_q,  dat_valid_d;

  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  pick_nxt;
  logic [LEN_W-1:0]  pick_len;
  logic              more_to_issue;
  logic              rd_en;
  logic              vld_acc;
  logic              starving;
  logic              burst_full;
  logic              timed_out;

  // Round-robin search: first set request at or above ptr_q, wrapping.
  always_comb begin
    int k;
    int nx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      if (!pick_found && req_i[k]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(k);
      end
    end
    nx = int'(pick_idx) + 1;
    if (nx >= N_REQ) begin
      nx = 0;
    end
    pick_nxt = PTR_W'(nx);
    pick_len = req_len_i[int'(pick_idx)*LEN_W +: LEN_W];
  end

  always_comb begin
    more_to_issue = (issued_q < {1'b0, len_q});
    rd_en         = (state_q == S_BURST) && more_to_issue && !fifo_empty_i;
    starving      = (state_q == S_BURST) && more_to_issue && fifo_empty_i;
    vld_acc       = fifo_rd_dat_valid_i && ((state_q == S_BURST) || (state_q == S_DRAIN));
    burst_full    = (rcvd_q == {1'b0, len_q});
    timed_out     = (ecnt_q == ECNT_W'(TIMEOUT));
  end

  // State register plus the burst datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      rcvd_q      <= '0;
      ecnt_q      <= '0;
      err_pend_q  <= 1'b0;
      gnt_q       <= '0;
      dat_q       <= '0;
      dat_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      rcvd_q      <= rcvd_d;
      ecnt_q      <= ecnt_d;
      err_pend_q  <= err_pend_d;
      gnt_q       <= gnt_d;
      dat_q       <= dat_d;
      dat_valid_q <= dat_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (burst_full) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rcvd_q == issued_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    len_d       = len_q;
    gnt_d       = gnt_q;
    err_pend_d  = err_pend_q;
    issued_d    = issued_q + CNT_W'(rd_en);
    rcvd_d      = rcvd_q + CNT_W'(vld_acc);
    ecnt_d      = ecnt_q;
    if (rd_en) begin
      ecnt_d = '0;
    end else if (starving && !timed_out) begin
      ecnt_d = ecnt_q + 1'b1;
    end
    dat_d       = vld_acc ? fifo_rd_dat_i : dat_q;
    dat_valid_d = vld_acc ? gnt_q : '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          len_d           = pick_len;
          ptr_d           = pick_nxt;
          issued_d        = '0;
          rcvd_d          = '0;
          ecnt_d          = '0;
          err_pend_d      = 1'b0;
        end
      end
      S_BURST: begin
        if (!burst_full && timed_out) begin
          err_pend_d = 1'b1;
        end
      end
      S_DONE: begin
        gnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    gnt_o       = gnt_q;
    fifo_rd_o   = rd_en;
    dat_o       = dat_q;
    dat_valid_o = dat_valid_q;
    done_o      = '0;
    err_o       = '0;
    if (state_q == S_DONE) begin
      if (err_pend_q) begin
        err_o = gnt_q;
      end else begin
        done_o = gnt_q;
      end
    end
  end

endmodule
`default_nettype wire
